scpu_prog_loader: RTL and testbench
===================================

Name: scpu_prog_loader

Overview:
- Upstream stage of the 8-bit serial CPU: owns the 512x8 instruction memory and the CPU run control.
- Accepts a program as a byte stream over a valid/ready port and stores it from address 0.
- When loading completes, raises cpu_enable and pulses cpu_start. It then serves CPU instruction fetches: CPU presents i_addr, and the loader returns the byte on i_data one cycle later.
- Instructions are stored low byte at the even address, high byte at the odd address, matching the CPU's two-beat fetch.

Parameters:
- ADDR_W, 9, instruction byte-address width (matches CPU i_addr).
- DATA_W, 8, byte width.
- DEPTH, 512, memory depth in bytes; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_load  in  1  one-cycle pulse: start (or restart) a program load.
- ld_valid  in  1  stream byte valid.
- ld_data  in  DATA_W  stream byte.
- ld_last  in  1  qualifies the final byte of the program (sampled with ld_valid).
- ld_ready  out  1  loader accepts a byte this cycle.
- i_addr  in  ADDR_W  CPU instruction byte address.
- i_data  out  DATA_W  instruction byte to CPU i_datain, registered.
- cpu_enable  out  1  CPU enable.
- cpu_start  out  1  one-cycle CPU start pulse.
- busy  out  1  high in LOAD and START states.
- load_cnt  out  ADDR_W+1  bytes stored in the current load, saturates at DEPTH.
- err_ovf  out  1  sticky overflow flag.
- err_csum  out  1  sticky checksum error (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, state IDLE, write pointer 0. Memory contents are not cleared.
- Beat rule: a beat transfers when ld_valid && ld_ready. ld_ready = 1 only in state LOAD.
- State IDLE: cpu_enable=0, i_data=0.
  - cmd_load -> LOAD. Clears the write pointer, load_cnt, err_ovf and err_csum.
- State LOAD: cpu_enable=0, i_data=0.
  - Each beat writes ld_data to mem[ptr], then ptr++ and load_cnt++.
  - Beat with ld_last and no error -> START on the next edge.
  - Beat with ld_last and err_ovf (or err_csum) set -> IDLE, no start.
- Overflow:
  - When load_cnt==DEPTH, any further beat is still accepted (stream drains), but it is not written.
  - Such a beat sets err_ovf; ptr does not wrap and load_cnt holds at 512.
  - If the 512th stored byte carries ld_last, that is a normal completion, not an overflow.
- State START: exactly one cycle. cpu_enable=1, cpu_start=1 -> RUN.
  - cpu_start rises the cycle after the ld_last beat.
- State RUN: cpu_enable=1, cpu_start=0, i_data <= mem[i_addr] every cycle (1-cycle read latency).
  - cmd_load -> LOAD. cpu_enable drops on the next edge (the CPU is stopped), and LOAD's clears apply.
- cmd_load in LOAD: restarts the load. The pointer and counters clear; a beat transferred in the same cycle is consumed and discarded.
- cmd_load in START: ignored.
- busy = 1 in LOAD and START.
- rst mid-load or mid-run: immediate return to reset values; a partial program stays in memory but is never started.

Optional Feature:
- Macro: SCPU_LOADER_CHECKSUM_EN.
- Defined:
  - The ld_last byte is a checksum and is not stored.
  - The 8-bit modular sum of all stored bytes plus the checksum byte must equal 0x00.
  - On mismatch: err_csum=1 (sticky until the next cmd_load or rst), return to IDLE, no cpu_start.
  - load_cnt excludes the checksum byte.
- Not defined:
  - The ld_last byte is stored like any other byte.
  - err_csum is tied to 0.

Test Plan:
- Basic load and fetch:
  - Stimulus: cmd_load, then bytes 0x10,0x08,0x11,0x09 (last on 0x09), macro off.
  - Response: load_cnt=4; cpu_start high for exactly 1 cycle, 1 cycle after the last beat; cpu_enable stays 1.
  - Then i_addr=2 -> i_data=0x11 on the next cycle; i_addr=3 -> 0x09.
- Backpressure and gaps:
  - Stimulus: same program with ld_valid low on alternate cycles.
  - Response: identical memory contents; ld_ready=0 before cmd_load and after last.
- Overflow:
  - Stimulus: 513 bytes, 0x00..0xFF repeating, last on the 513th.
  - Response: err_ovf=1, load_cnt=512, no cpu_start, state IDLE, mem[511]=0xFF.
- Reset mid-load:
  - Stimulus: assert rst after 3 of 4 bytes.
  - Response: all outputs 0 immediately; a new cmd_load and full load then starts normally.
- Reload during RUN:
  - Stimulus: cmd_load while running.
  - Response: cpu_enable=0 on the next cycle, busy=1, load_cnt=0. A new 2-byte program 0x00,0x98 then starts the CPU again.
- Checksum (macro on):
  - Stimulus: bytes 0x10,0x08 plus checksum 0xE8.
  - Response: start pulse, load_cnt=2.
  - Stimulus: same bytes with checksum 0xE7.
  - Response: err_csum=1, no start, IDLE.

Source files
------------

// File: rtl/scpu_prog_loader.sv
//-----------------------------------------------------------------------------
// scpu_prog_loader
//
// Upstream stage of the 8-bit serial CPU. Owns the instruction memory and the
// CPU run control:
//   - IDLE : waiting for cmd_load.
//   - LOAD : accepts a program as a valid/ready byte stream and stores it
//            from address 0 (low byte even address, high byte odd address).
//   - START: one cycle with cpu_enable=1 and cpu_start=1.
//   - RUN  : serves CPU fetches, i_data <= mem[i_addr] (one-cycle latency).
//
// Optional feature (macro SCPU_LOADER_CHECKSUM_EN):
//   defined     : the ld_last byte is a checksum, not stored and not counted;
//                 the 8-bit sum of stored bytes plus checksum must be 0x00,
//                 otherwise err_csum is set and the CPU is not started.
//   not defined : the ld_last byte is stored like any other; err_csum = 0.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   cmd_load         one-cycle pulse: start or restart a program load
//   ld_valid/ld_data/ld_last/ld_ready   program byte stream
//   i_addr / i_data  CPU instruction fetch address / registered byte
//   cpu_enable       CPU enable (START and RUN)
//   cpu_start        one-cycle CPU start pulse (START)
//   busy             high in LOAD and START
//   load_cnt         bytes stored in the current load, saturates at DEPTH
//   err_ovf          sticky overflow flag
//   err_csum         sticky checksum error flag
//
// DEPTH must equal 2**ADDR_W.
//-----------------------------------------------------------------------------
module scpu_prog_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_load,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    output logic              cpu_enable,
    output logic              cpu_start,
    output logic              busy,
    output logic [ADDR_W:0]   load_cnt,
    output logic              err_ovf,
    output logic              err_csum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     load_cnt_q, load_cnt_d;
    logic                err_ovf_q, err_ovf_d;
    logic [DATA_W-1:0]   i_data_q, i_data_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                beat;
    logic                do_clear;
    logic                cnt_full;
    logic                store_beat;
    logic                store_ok;
    logic                csum_bad;
    logic                wr_en;

    assign ld_ready = (state_q == S_LOAD);
    assign beat     = ld_valid && ld_ready;

    // cmd_load clears the load bookkeeping everywhere except START, where it
    // is ignored. In LOAD a beat in the same cycle is swallowed.
    assign do_clear = cmd_load && (state_q != S_START);

    // The write pointer is the low ADDR_W bits of load_cnt; once load_cnt
    // reaches DEPTH no further byte is written, so the pointer never wraps.
    assign cnt_full = (load_cnt_q == FULL_CNT);

    // store_ok: this beat is a program byte that lands in memory.
    assign store_ok = store_beat && !cmd_load && !cnt_full;

`ifdef SCPU_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] csum_total;
    logic              err_csum_q, err_csum_d;

    // The checksum byte completes the load, it is never stored.
    assign store_beat = beat && !ld_last;
    assign csum_total = csum_q + ld_data;
    assign csum_bad   = beat && !cmd_load && ld_last && (csum_total != '0);

    always_comb begin
        csum_d     = csum_q;
        err_csum_d = err_csum_q;
        if (store_ok) begin
            csum_d = csum_total;
        end
        if (csum_bad) begin
            err_csum_d = 1'b1;
        end
        if (do_clear) begin
            csum_d     = '0;
            err_csum_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q     <= '0;
            err_csum_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            err_csum_q <= err_csum_d;
        end
    end

    assign err_csum = err_csum_q;
`else
    assign store_beat = beat;
    assign csum_bad   = 1'b0;
    assign err_csum   = 1'b0;
`endif

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        err_ovf_d  = err_ovf_q;
        i_data_d   = '0;
        wr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_load) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (!cmd_load && beat) begin
                    if (store_ok) begin
                        wr_en      = 1'b1;
                        load_cnt_d = load_cnt_q + 1'b1;
                    end else if (store_beat) begin
                        // Memory full: drain the byte and flag the overflow.
                        err_ovf_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = (err_ovf_d || csum_bad) ? S_IDLE : S_START;
                    end
                end
            end

            S_START: begin
                state_d = S_RUN;
            end

            S_RUN: begin
                if (cmd_load) begin
                    state_d = S_LOAD;
                end else begin
                    i_data_d = mem[i_addr];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_clear) begin
            load_cnt_d = '0;
            err_ovf_d  = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            err_ovf_q  <= 1'b0;
            i_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            err_ovf_q  <= err_ovf_d;
            i_data_q   <= i_data_d;
        end
    end

    // NOTE: the memory array has no reset; a partial program survives rst and
    // a reset-free array maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[load_cnt_q[ADDR_W-1:0]] <= ld_data;
        end
    end

    assign i_data     = i_data_q;
    assign cpu_enable = (state_q == S_START) || (state_q == S_RUN);
    assign cpu_start  = (state_q == S_START);
    assign busy       = (state_q == S_LOAD) || (state_q == S_START);
    assign load_cnt   = load_cnt_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_scpu_prog_loader.sv
`timescale 1ns/1ps
module tb_scpu_prog_loader;

`ifdef SCPU_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_load;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic [8:0] i_addr;
    logic [7:0] i_data;
    logic       cpu_enable;
    logic       cpu_start;
    logic       busy;
    logic [9:0] load_cnt;
    logic       err_ovf;
    logic       err_csum;

    scpu_prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_load   (cmd_load),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .cpu_enable (cpu_enable),
        .cpu_start  (cpu_start),
        .busy       (busy),
        .load_cnt   (load_cnt),
        .err_ovf    (err_ovf),
        .err_csum   (err_csum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 loading, 2 start pulse, 3 running
    int         m_mode;
    int         m_cnt;
    bit         m_ovf;
    bit         m_cerr;
    int         m_sum;
    bit         m_bad;
    bit         m_store;
    logic [7:0] m_mem [512];
    bit         m_wr  [512];
    logic [7:0] m_idata;
    bit         m_known;
    int         start_seen = 0;

    initial begin
        for (int i = 0; i < 512; i++) m_wr[i] = 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_ovf = 0; m_cerr = 0; m_sum = 0;
            m_idata = 8'h00; m_known = 1'b1;
        end else begin
            if (m_mode == 3 && !cmd_load) begin
                m_idata = m_mem[i_addr];
                m_known = m_wr[i_addr];
            end else begin
                m_idata = 8'h00;
                m_known = 1'b1;
            end
            if (cmd_load && m_mode != 2) begin
                m_mode = 1; m_cnt = 0; m_ovf = 0; m_cerr = 0; m_sum = 0;
            end else if (m_mode == 2) begin
                m_mode = 3;
            end else if (m_mode == 1 && ld_valid) begin
                m_store = !(CSUM && ld_last);
                m_bad   = CSUM && ld_last && (((m_sum + ld_data) % 256) != 0);
                if (m_store) begin
                    if (m_cnt == 512) m_ovf = 1'b1;
                    else begin
                        m_mem[m_cnt] = ld_data;
                        m_wr[m_cnt]  = 1'b1;
                        m_cnt++;
                        m_sum += ld_data;
                    end
                end
                if (ld_last) begin
                    if (m_bad) m_cerr = 1'b1;
                    m_mode = (m_ovf || m_bad) ? 0 : 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("m_ld_ready",   ld_ready,   m_mode == 1);
        check("m_busy",       busy,       m_mode == 1 || m_mode == 2);
        check("m_cpu_enable", cpu_enable, m_mode == 2 || m_mode == 3);
        check("m_cpu_start",  cpu_start,  m_mode == 2);
        check("m_load_cnt",   load_cnt,   m_cnt);
        check("m_err_ovf",    err_ovf,    m_ovf);
        check("m_err_csum",   err_csum,   m_cerr);
        if (m_known) check("m_i_data", i_data, m_idata);
        if (cpu_start) start_seen++;
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] prog [0:1023];
    int         prog_len;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input bit last);
        int n;
        n = 0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        while (!ld_ready && n < 50) begin
            tick();
            n++;
        end
        if (!ld_ready) check("ready_timeout", 32'd0, 32'd1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Sends prog[0:prog_len-1]; with the checksum build a correct checksum
    // byte is appended as the last beat.
    task automatic send_prog(input bit gap);
        int         total;
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        for (int i = 0; i < prog_len; i++) cs = cs - prog[i];
        total = prog_len + (CSUM ? 1 : 0);
        for (int i = 0; i < total; i++) begin
            b = (i < prog_len) ? prog[i] : cs;
            beat(b, i == total - 1);
            if (gap && i != total - 1) begin
                ld_valid = 1'b0;
                ld_last  = 1'b1;
                ld_data  = 8'hFF;
                tick();
                ld_last  = 1'b0;
            end
        end
    endtask

    task automatic fetch(input logic [8:0] a, input logic [7:0] exp);
        i_addr = a;
        tick();
        check("fetch", i_data, exp);
    endtask

    task automatic set_basic();
        prog[0] = 8'h10; prog[1] = 8'h08; prog[2] = 8'h11; prog[3] = 8'h09;
        prog_len = 4;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s0;

    initial begin
        rst = 1'b1; cmd_load = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        ld_last = 1'b0; i_addr = '0;
        repeat (3) tick();
        check("rst_ld_ready", ld_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cpu_enable", cpu_enable, 0);
        check("rst_cpu_start", cpu_start, 0);
        check("rst_load_cnt", load_cnt, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_err_csum", err_csum, 0);
        check("rst_i_data", i_data, 0);
        rst = 1'b0;
        tick();

        // Basic load and fetch
        check("ready_before_cmd", ld_ready, 0);
        set_basic();
        s0 = start_seen;
        pulse_load();
        send_prog(1'b0);
        check("basic_start_after_last", cpu_start, 1);
        check("basic_load_cnt", load_cnt, 4);
        check("basic_ready_after_last", ld_ready, 0);
        tick();
        check("basic_start_drops", cpu_start, 0);
        check("basic_enable_holds", cpu_enable, 1);
        fetch(9'd2, 8'h11);
        fetch(9'd3, 8'h09);
        check("basic_start_once", start_seen - s0, 1);

        // Backpressure and gaps
        check("ready_in_run", ld_ready, 0);
        pulse_load();
        send_prog(1'b1);
        check("gap_ready_after_last", ld_ready, 0);
        check("gap_load_cnt", load_cnt, 4);
        tick();
        fetch(9'd0, 8'h10);
        fetch(9'd1, 8'h08);
        fetch(9'd2, 8'h11);
        fetch(9'd3, 8'h09);

        // Exactly full memory is a normal completion
        for (int i = 0; i < 512; i++) prog[i] = 8'((i + 128) % 256);
        prog_len = 512;
        pulse_load();
        send_prog(1'b0);
        check("full_start", cpu_start, 1);
        check("full_load_cnt", load_cnt, 512);
        check("full_no_ovf", err_ovf, 0);
        tick();
        fetch(9'd511, 8'h7F);
        fetch(9'd0, 8'h80);

        // Overflow
        for (int i = 0; i < 513; i++) prog[i] = 8'(i % 256);
        prog_len = 513;
        s0 = start_seen;
        pulse_load();
        send_prog(1'b0);
        check("ovf_flag", err_ovf, 1);
        check("ovf_load_cnt", load_cnt, 512);
        check("ovf_idle", busy, 0);
        check("ovf_no_enable", cpu_enable, 0);
        repeat (2) tick();
        check("ovf_no_start", start_seen - s0, 0);
        check("ovf_sticky", err_ovf, 1);
        prog[0] = 8'h55; prog_len = 1;
        pulse_load();
        check("ovf_cleared", err_ovf, 0);
        send_prog(1'b0);
        tick();
        fetch(9'd511, 8'hFF);
        fetch(9'd1, 8'h01);
        fetch(9'd0, 8'h55);

        // Reset mid-load
        pulse_load();
        beat(8'h21, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h23, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_load_cnt", load_cnt, 0);
        check("midrst_ready", ld_ready, 0);
        check("midrst_enable", cpu_enable, 0);
        tick();
        rst = 1'b0;
        tick();
        set_basic();
        pulse_load();
        send_prog(1'b0);
        check("postrst_start", cpu_start, 1);
        tick();
        fetch(9'd0, 8'h10);

        // Reload during RUN
        pulse_load();
        check("reload_enable_drop", cpu_enable, 0);
        check("reload_busy", busy, 1);
        check("reload_load_cnt", load_cnt, 0);
        prog[0] = 8'h00; prog[1] = 8'h98; prog_len = 2;
        send_prog(1'b0);
        check("reload_start", cpu_start, 1);
        check("reload_load_cnt2", load_cnt, 2);
        tick();
        fetch(9'd1, 8'h98);

        // Restart inside LOAD: the beat coinciding with cmd_load is discarded
        pulse_load();
        beat(8'h33, 1'b0);
        cmd_load = 1'b1; ld_valid = 1'b1; ld_data = 8'h44; ld_last = 1'b0;
        tick();
        cmd_load = 1'b0; ld_valid = 1'b0;
        check("restart_cnt", load_cnt, 0);
        prog[0] = 8'h66; prog[1] = 8'h77; prog_len = 2;
        send_prog(1'b0);
        check("restart_load_cnt", load_cnt, 2);
        tick();
        fetch(9'd0, 8'h66);
        fetch(9'd1, 8'h77);

`ifdef SCPU_LOADER_CHECKSUM_EN
        // Checksum good then bad
        pulse_load();
        beat(8'h10, 1'b0);
        beat(8'h08, 1'b0);
        beat(8'hE8, 1'b1);
        check("csum_good_start", cpu_start, 1);
        check("csum_good_cnt", load_cnt, 2);
        check("csum_good_flag", err_csum, 0);
        tick();
        s0 = start_seen;
        pulse_load();
        beat(8'h10, 1'b0);
        beat(8'h08, 1'b0);
        beat(8'hE7, 1'b1);
        check("csum_bad_flag", err_csum, 1);
        check("csum_bad_no_start", cpu_start, 0);
        check("csum_bad_idle", busy, 0);
        repeat (2) tick();
        check("csum_bad_sticky", err_csum, 1);
        check("csum_bad_no_pulse", start_seen - s0, 0);
`else
        check("csum_tied_low", err_csum, 0);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
